// File: rtl/ula_cmp_seq_if.sv
// Handshake and data bundle for the ULA multi-cycle comparison unit.
// The master side presents operands and consumes the result; the slave
// side is the comparator itself.
interface ula_cmp_seq_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 2 * WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           op;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 eq_flag;
  logic                 lt_flag;
  logic                 op_err;

  modport master (
    output in_valid, a, b, op, is_signed, out_ready,
    input  in_ready, out_valid, out, eq_flag, lt_flag, op_err
  );

  modport slave (
    input  in_valid, a, b, op, is_signed, out_ready,
    output in_ready, out_valid, out, eq_flag, lt_flag, op_err
  );
endinterface

// File: rtl/ula_cmp_seq.sv
// ula_cmp_seq: multi-cycle comparator for the ULA result mux path.
// Walks the operands CHUNK bits per cycle starting at the MSB chunk and
// produces EQ/NE/LT/LTE/GT/GTE, signed or unsigned, with the result bit
// placed at out[OUT_WIDTH-1].
// Optional feature macro: ULA_CMP_EARLY_EXIT_EN -- when defined, the walk
// stops at the first differing chunk; otherwise every chunk is visited and
// the first difference is latched, giving a fixed latency.
module ula_cmp_seq #(
  parameter int WIDTH     = 8,
  parameter int CHUNK     = 2,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input logic           clk,
  input logic           rst,
  ula_cmp_seq_if.slave  bus
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IDXW-1:0]  r_idx;
`ifndef ULA_CMP_EARLY_EXIT_EN
  logic             r_found;
  logic             r_lt;
`endif

  logic [WIDTH-1:0] w_msb_flip;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_diff;
  logic             w_lt_chunk;
  logic             w_last;
  logic             w_decide;
  logic             w_fin_eq;
  logic             w_fin_lt;
  logic             w_result;
  logic             w_err;

  // Flipping the sign bit at capture turns a two's-complement compare into
  // an unsigned one, so the chunk walk never needs to know about signedness.
  assign w_msb_flip = {bus.is_signed, {(WIDTH-1){1'b0}}};

  assign w_a_chunk  = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_chunk  = r_b[r_idx*CHUNK +: CHUNK];
  assign w_diff     = (w_a_chunk != w_b_chunk);
  assign w_lt_chunk = (w_a_chunk < w_b_chunk);
  assign w_last     = (r_idx == '0);
  assign w_err      = r_op[2] & r_op[1];

  assign bus.in_ready = (r_state == ST_IDLE) && !rst;

  // Decide when the walk ends and what the final eq/lt outcome is.
  always_comb begin
    w_decide = 1'b0;
    w_fin_eq = 1'b0;
    w_fin_lt = 1'b0;
`ifdef ULA_CMP_EARLY_EXIT_EN
    w_decide = w_diff || w_last;
    w_fin_eq = !w_diff;
    w_fin_lt = w_diff && w_lt_chunk;
`else
    w_decide = w_last;
    w_fin_eq = !(r_found || w_diff);
    w_fin_lt = r_found ? r_lt : (w_diff && w_lt_chunk);
`endif
  end

  // Map the eq/lt outcome onto the requested operation; illegal ops give 0.
  always_comb begin
    w_result = 1'b0;
    case (r_op)
      3'b000:  w_result = w_fin_eq;
      3'b001:  w_result = !w_fin_eq;
      3'b010:  w_result = w_fin_lt;
      3'b011:  w_result = w_fin_lt || w_fin_eq;
      3'b100:  w_result = !w_fin_lt && !w_fin_eq;
      3'b101:  w_result = !w_fin_lt;
      default: w_result = 1'b0;
    endcase
  end

  // Control FSM: capture in IDLE, walk chunks in BUSY, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= '0;
      r_idx         <= '0;
`ifndef ULA_CMP_EARLY_EXIT_EN
      r_found       <= 1'b0;
      r_lt          <= 1'b0;
`endif
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.eq_flag   <= 1'b0;
      bus.lt_flag   <= 1'b0;
      bus.op_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            r_a     <= bus.a ^ w_msb_flip;
            r_b     <= bus.b ^ w_msb_flip;
            r_op    <= bus.op;
            r_idx   <= IDXW'(N - 1);
`ifndef ULA_CMP_EARLY_EXIT_EN
            r_found <= 1'b0;
            r_lt    <= 1'b0;
`endif
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_decide) begin
            bus.out       <= {w_result && !w_err, {(OUT_WIDTH-1){1'b0}}};
            bus.eq_flag   <= w_fin_eq;
            bus.lt_flag   <= w_fin_lt;
            bus.op_err    <= w_err;
            bus.out_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
`ifndef ULA_CMP_EARLY_EXIT_EN
            if (!r_found && w_diff) begin
              r_found <= 1'b1;
              r_lt    <= w_lt_chunk;
            end
`endif
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_cmp_seq.sv
// Testbench for ula_cmp_seq: directed cases followed by random transactions,
// all checked against a plain arithmetic reference model.
module tb_ula_cmp_seq;

  localparam int WIDTH     = 8;
  localparam int CHUNK     = 2;
  localparam int OUT_WIDTH = 2 * WIDTH;
  localparam int N         = WIDTH / CHUNK;

  logic clk;
  logic rst;
  int   nCmp;
  int   nFail;

  ula_cmp_seq_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) busIf ();

  ula_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: cycles from accept edge to out_valid visible.
  function automatic int expLatency(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
`ifdef ULA_CMP_EARLY_EXIT_EN
    for (int k = 1; k <= N; k++) begin
      if (ta[WIDTH-k*CHUNK +: CHUNK] != tb[WIDTH-k*CHUNK +: CHUNK]) return k;
    end
    return N;
`else
    return N;
`endif
  endfunction

  // Full transaction: wait ready, accept, time the result, hold, handshake.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic [2:0] top, input logic tsgn, input int holdCycles);
    int guard;
    int lat;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic expEq, expLt, expRes, expErr;
    logic [OUT_WIDTH-1:0] expOut;

    sa = ta;
    sb = tb;
    expEq = (ta == tb);
    expLt = tsgn ? (sa < sb) : (ta < tb);
    expErr = (top >= 3'd6);
    case (top)
      3'd0: expRes = expEq;
      3'd1: expRes = !expEq;
      3'd2: expRes = expLt;
      3'd3: expRes = expLt || expEq;
      3'd4: expRes = !expLt && !expEq;
      3'd5: expRes = !expLt;
      default: expRes = 1'b0;
    endcase
    expOut = expRes ? (OUT_WIDTH'(1) << (OUT_WIDTH-1)) : '0;

    @(posedge clk); #1;
    guard = 0;
    while (!busIf.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("readyBeforeAccept", 32'(busIf.in_ready), 32'd1);

    busIf.in_valid  = 1'b1;
    busIf.a         = ta;
    busIf.b         = tb;
    busIf.op        = top;
    busIf.is_signed = tsgn;
    busIf.out_ready = 1'b0;
    @(posedge clk); #1;
    busIf.in_valid  = 1'($urandom_range(0, 1));
    busIf.a         = WIDTH'($urandom);
    busIf.b         = WIDTH'($urandom);
    busIf.op        = 3'($urandom);
    busIf.is_signed = 1'($urandom);

    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!busIf.out_valid && lat < 20);
    checkOutput("latency", 32'(lat), 32'(expLatency(ta, tb)));
    checkOutput("out", 32'(busIf.out), 32'(expOut));
    checkOutput("eqFlag", 32'(busIf.eq_flag), 32'(expEq));
    checkOutput("ltFlag", 32'(busIf.lt_flag), 32'(expLt));
    checkOutput("opErr", 32'(busIf.op_err), 32'(expErr));

    for (int i = 0; i < holdCycles; i++) begin
      busIf.in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("holdValid", 32'(busIf.out_valid), 32'd1);
      checkOutput("holdOut", 32'(busIf.out), 32'(expOut));
      checkOutput("holdFlags", 32'({busIf.eq_flag, busIf.lt_flag, busIf.op_err}),
                  32'({expEq, expLt, expErr}));
      checkOutput("holdInReady", 32'(busIf.in_ready), 32'd0);
    end

    busIf.out_ready = 1'b1;
    busIf.in_valid  = 1'b0;
    @(posedge clk); #1;
    busIf.out_ready = 1'b0;
    checkOutput("postHandshakeValid", 32'(busIf.out_valid), 32'd0);
    checkOutput("postHandshakeReady", 32'(busIf.in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    nCmp  = 0;
    nFail = 0;
    rst             = 1'b1;
    busIf.in_valid  = 1'b0;
    busIf.a         = '0;
    busIf.b         = '0;
    busIf.op        = '0;
    busIf.is_signed = 1'b0;
    busIf.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOut", 32'(busIf.out), 32'd0);
    checkOutput("resetValid", 32'(busIf.out_valid), 32'd0);
    checkOutput("resetFlags", 32'({busIf.eq_flag, busIf.lt_flag, busIf.op_err}), 32'd0);
    checkOutput("resetInReady", 32'(busIf.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("releaseInReady", 32'(busIf.in_ready), 32'd1);

    // Directed cases
    applyStimulus(8'h5A, 8'h5A, 3'b000, 1'b0, 0);
    applyStimulus(8'h80, 8'h01, 3'b010, 1'b0, 0);
    applyStimulus(8'h80, 8'h01, 3'b010, 1'b1, 0);
    applyStimulus(8'h03, 8'h02, 3'b101, 1'b0, 0);
    applyStimulus(8'h10, 8'h20, 3'b111, 1'b0, 0);
    applyStimulus(8'h10, 8'h20, 3'b110, 1'b1, 1);
    applyStimulus(8'hFF, 8'h00, 3'b100, 1'b1, 2);
    applyStimulus(8'h7F, 8'h80, 3'b011, 1'b0, 2);
    applyStimulus(8'h44, 8'h45, 3'b001, 1'b0, 1);

    // Reset in the middle of BUSY step 2
    @(posedge clk); #1;
    busIf.in_valid = 1'b1;
    busIf.a        = 8'hC3;
    busIf.b        = 8'hC3;
    busIf.op       = 3'b000;
    @(posedge clk); #1;
    busIf.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortValid", 32'(busIf.out_valid), 32'd0);
    checkOutput("abortOut", 32'(busIf.out), 32'd0);
    checkOutput("abortInReadyInReset", 32'(busIf.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("abortInReady", 32'(busIf.in_ready), 32'd1);
    repeat (N + 2) @(posedge clk);
    #1;
    checkOutput("abortStaysIdle", 32'(busIf.out_valid), 32'd0);

    // Random transactions
    for (int t = 0; t < 60; t++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      else if ($urandom_range(0, 3) == 0) rb = ra ^ WIDTH'($urandom_range(1, 3));
      applyStimulus(ra, rb, 3'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
